// File: rtl/burst_reader.sv
// -----------------------------------------------------------------------------
// burst_reader
//
// Drain-side controller for the burst ring buffer. A start command pops a
// programmed number of words (1..BURST_LENGTH) from the buffer read port and
// presents them to the compute datapath as a valid/ready stream. The final
// beat carries m_last and a one-cycle done pulse follows the burst.
//
// Optional feature macro: BURST_READER_STATS_EN
//   defined   : stall_cnt counts cycles with m_valid && !m_ready (saturating,
//               cleared on reset and on command acceptance)
//   undefined : stall counter compiled out, stall_cnt tied to zero
//
// Ports
//   clk, rst    : single rising-edge clock, synchronous active-high reset
//   start       : command strobe, only looked at in IDLE
//   start_len   : beats to move; 0 or > BURST_LENGTH is rejected
//   busy        : high from command acceptance until done
//   done        : one-cycle pulse after the last beat handshake
//   cmd_err     : one-cycle pulse after a rejected start
//   buf_empty   : buffer empty flag
//   buf_ren     : buffer pop strobe
//   buf_dout    : buffer read data, valid the cycle after buf_ren
//   m_valid/m_ready/m_data/m_last : output stream
//   beat_cnt    : beats handshaked in the current command
//   stall_cnt   : back-pressure stall cycles (see macro above)
// -----------------------------------------------------------------------------
module burst_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_LENGTH = 128,
    parameter int LEN_WIDTH    = $clog2(BURST_LENGTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  start_len,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_err,
    input  logic                  buf_empty,
    output logic                  buf_ren,
    input  logic [DATA_WIDTH-1:0] buf_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [LEN_WIDTH-1:0]  beat_cnt,
    output logic [31:0]           stall_cnt
);

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  LEN_MAX   = LEN_WIDTH'(BURST_LENGTH);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A command length is usable when it is non-zero and fits the buffer.
    function automatic logic len_is_legal(input logic [LEN_WIDTH-1:0] len);
        len_is_legal = (len != LEN_ZERO) && (len <= LEN_MAX);
    endfunction

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    pop_rem_q, pop_rem_d;
    logic [LEN_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic                    inflight_q, inflight_d;
    logic [1:0]              qcnt_q, qcnt_d;
    logic [DATA_WIDTH-1:0]   q0_q, q0_d;
    logic [DATA_WIDTH-1:0]   q1_q, q1_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cmd_err_q, cmd_err_d;

    logic                    accept_s;
    logic                    reject_s;
    logic                    m_valid_s;
    logic                    hs_s;
    logic [2:0]              occ_s;
    logic                    buf_ren_s;
    logic                    m_last_s;
    logic [DATA_WIDTH-1:0]   m_data_s;

    // Command decode, stream handshake and pop decision.
    always_comb begin
        accept_s  = (state_q == ST_IDLE) && start && len_is_legal(start_len);
        reject_s  = (state_q == ST_IDLE) && start && !len_is_legal(start_len);
        // The word in flight is offered directly so the first beat appears
        // the cycle its data arrives, not one cycle later.
        m_valid_s = (qcnt_q != 2'd0) || inflight_q;
        hs_s      = m_valid_s && m_ready;
        // Words held after this cycle if nothing new were popped; a beat
        // leaving this cycle frees its slot immediately.
        occ_s     = {1'b0, qcnt_q} + {2'b00, inflight_q} - {2'b00, hs_s};
        buf_ren_s = (state_q == ST_RUN) && !buf_empty &&
                    (pop_rem_q != LEN_ZERO) && (occ_s < 3'd2);
        m_last_s  = m_valid_s && (beat_cnt_q == (len_q - LEN_ONE));
    end

    // Stream data source: queue head first, otherwise the arriving word.
    always_comb begin
        m_data_s = DATA_ZERO;
        if (qcnt_q != 2'd0) begin
            m_data_s = q0_q;
        end else if (inflight_q) begin
            m_data_s = buf_dout;
        end else begin
            m_data_s = DATA_ZERO;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hs_s && m_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command length, pop budget, beat counter and in-flight tracking.
    always_comb begin
        len_d      = len_q;
        pop_rem_d  = pop_rem_q;
        beat_cnt_d = beat_cnt_q;
        inflight_d = buf_ren_s;
        if (accept_s) begin
            len_d      = start_len;
            pop_rem_d  = start_len;
            beat_cnt_d = LEN_ZERO;
        end else begin
            if (buf_ren_s) begin
                pop_rem_d = pop_rem_q - LEN_ONE;
            end else begin
                pop_rem_d = pop_rem_q;
            end
            if (hs_s) begin
                beat_cnt_d = beat_cnt_q + LEN_ONE;
            end else begin
                beat_cnt_d = beat_cnt_q;
            end
        end
    end

    // Two-entry output queue: q0 is the head, q1 the tail.
    always_comb begin
        logic                  head_pop;
        logic                  bypass;
        logic                  push;
        logic [1:0]            cnt_after_pop;
        q0_d          = q0_q;
        q1_d          = q1_q;
        qcnt_d        = qcnt_q;
        head_pop      = hs_s && (qcnt_q != 2'd0);
        // An empty queue means the accepted beat was the in-flight word,
        // which then never needs to be stored.
        bypass        = hs_s && (qcnt_q == 2'd0);
        push          = inflight_q && !bypass;
        cnt_after_pop = qcnt_q;
        if (head_pop) begin
            q0_d          = q1_q;
            cnt_after_pop = qcnt_q - 2'd1;
        end else begin
            cnt_after_pop = qcnt_q;
        end
        if (push) begin
            if (cnt_after_pop == 2'd0) begin
                q0_d = buf_dout;
            end else begin
                q1_d = buf_dout;
            end
            qcnt_d = cnt_after_pop + 2'd1;
        end else begin
            qcnt_d = cnt_after_pop;
        end
    end

    // Registered status outputs follow the next FSM state.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        cmd_err_d = reject_s;
    end

    // State, counters, queue and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= LEN_ZERO;
            pop_rem_q  <= LEN_ZERO;
            beat_cnt_q <= LEN_ZERO;
            inflight_q <= 1'b0;
            qcnt_q     <= 2'd0;
            q0_q       <= DATA_ZERO;
            q1_q       <= DATA_ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            pop_rem_q  <= pop_rem_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= inflight_d;
            qcnt_q     <= qcnt_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

`ifdef BURST_READER_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating back-pressure stall counter, restarted per command.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (accept_s) begin
            stall_cnt_d = 32'd0;
        end else if (m_valid_s && !m_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign cmd_err  = cmd_err_q;
    assign buf_ren  = buf_ren_s;
    assign m_valid  = m_valid_s;
    assign m_data   = m_data_s;
    assign m_last   = m_last_s;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_burst_reader
//
// Directed bench for burst_reader. A small queue-based ring buffer model
// serves buf_ren pops; expected beats are pushed to a scoreboard when the
// words are written and compared against every valid beat.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_burst_reader;

    localparam int DW = 32;
    localparam int BL = 128;
    localparam int LW = $clog2(BL) + 1;

`ifdef BURST_READER_STATS_EN
    localparam logic [31:0] EXP_STALL = 32'd64;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] start_len;
    logic          busy;
    logic          done;
    logic          cmd_err;
    logic          buf_empty;
    logic          buf_ren;
    logic [DW-1:0] buf_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [LW-1:0] beat_cnt;
    logic [31:0]   stall_cnt;

    beat_t         sb[$];
    logic [DW-1:0] mem[$];

    int vectors     = 0;
    int miscompares = 0;
    int ren_total   = 0;
    int hs_total    = 0;
    int outstanding = 0;
    bit cyc_ren     = 1'b0;
    bit cyc_hs      = 1'b0;
    bit err_seen    = 1'b0;
    int bad_lens[2] = '{0, 129};

    always #5 clk = ~clk;

    burst_reader #(
        .DATA_WIDTH   (DW),
        .BURST_LENGTH (BL),
        .LEN_WIDTH    (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_len (start_len),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err),
        .buf_empty (buf_empty),
        .buf_ren   (buf_ren),
        .buf_dout  (buf_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .beat_cnt  (beat_cnt),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic buf_write(input logic [DW-1:0] d);
        mem.push_back(d);
        buf_empty = 1'b0;
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        sb.push_back(b);
    endtask

    task automatic flush_model();
        sb.delete();
        mem.delete();
        buf_empty   = 1'b1;
        buf_dout    = 32'd0;
        outstanding = 0;
    endtask

    // Falling-edge observation with the always-on stream checks.
    task automatic sample();
        @(negedge clk);
        cyc_ren = buf_ren;
        cyc_hs  = m_valid && m_ready;
        if (cmd_err) err_seen = 1'b1;
        if (buf_ren) check("ren_while_empty", 64'(buf_empty), 64'd0);
        if (m_valid) begin
            check("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                check("m_data", 64'(m_data), 64'(sb[0].data));
                check("m_last", 64'(m_last), 64'(sb[0].last));
                if (cyc_hs) void'(sb.pop_front());
            end
        end
        outstanding = outstanding + int'(cyc_ren) - int'(cyc_hs);
        check("occupancy_le2", 64'(outstanding > 2), 64'd0);
    endtask

    // Rising edge plus buffer model: a pop presents the next word afterwards.
    task automatic advance();
        @(posedge clk);
        #1;
        if (cyc_ren && (mem.size() != 0)) buf_dout = mem.pop_front();
        buf_empty = (mem.size() == 0);
        if (cyc_ren) ren_total++;
        if (cyc_hs) hs_total++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_cmd_err"},   64'(cmd_err),   64'd0);
        check({tag, "_buf_ren"},   64'(buf_ren),   64'd0);
        check({tag, "_m_valid"},   64'(m_valid),   64'd0);
        check({tag, "_m_last"},    64'(m_last),    64'd0);
        check({tag, "_m_data"},    64'(m_data),    64'd0);
        check({tag, "_beat_cnt"},  64'(beat_cnt),  64'd0);
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    endtask

    task automatic run_to_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int c = 0; (c < budget) && !seen; c++) begin
            sample();
            if (done) seen = 1'b1;
            advance();
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic issue(input logic [LW-1:0] len);
        start_len = len;
        start     = 1'b1;
        sample();
        advance();
        start     = 1'b0;
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        start     = 1'b0;
        start_len = '0;
        m_ready   = 1'b0;
        buf_empty = 1'b1;
        buf_dout  = 32'd0;

        // Reset state
        advance();
        advance();
        sample();
        check_idle("reset");
        advance();
        rst = 1'b0;

        // Test 1: 8 words 0x10..0x17, full-rate stream, exact cycle timing
        for (int i = 0; i < 8; i++) begin
            buf_write(32'h10 + 32'(i));
            expect_beat(32'h10 + 32'(i), (i == 7));
        end
        m_ready   = 1'b1;
        ren_total = 0;
        hs_total  = 0;
        issue(8'd8);
        for (int c = 1; c <= 11; c++) begin
            sample();
            check("t1_buf_ren", 64'(buf_ren), 64'((c >= 1) && (c <= 8)));
            check("t1_m_valid", 64'(m_valid), 64'((c >= 2) && (c <= 9)));
            check("t1_m_last",  64'(m_last),  64'(c == 9));
            check("t1_busy",    64'(busy),    64'(c <= 10));
            check("t1_done",    64'(done),    64'(c == 10));
            advance();
        end
        check("t1_ren_pulses", 64'(ren_total), 64'd8);
        check("t1_beats",      64'(hs_total),  64'd8);
        check("t1_beat_cnt",   64'(beat_cnt),  64'd8);
        check("t1_sb_drained", 64'(sb.size()), 64'd0);

        // Test 2: 128 words with periodic back-pressure (low, high, high)
        for (int i = 0; i < 128; i++) begin
            buf_write(32'hA000_0000 + 32'(i));
            expect_beat(32'hA000_0000 + 32'(i), (i == 127));
        end
        ren_total = 0;
        hs_total  = 0;
        m_ready   = 1'b0;
        issue(8'd128);
        seen = 1'b0;
        for (int c = 1; (c <= 400) && !seen; c++) begin
            m_ready = (c >= 2) && (((c - 2) % 3) != 0);
            sample();
            if (done) seen = 1'b1;
            advance();
        end
        m_ready = 1'b1;
        check("t2_done_seen",  64'(seen),      64'd1);
        check("t2_beats",      64'(hs_total),  64'd128);
        check("t2_ren_pulses", 64'(ren_total), 64'd128);
        check("t2_stall_cnt",  64'(stall_cnt), 64'(EXP_STALL));
        check("t2_sb_drained", 64'(sb.size()), 64'd0);

        // Test 3: buffer runs dry after 2 of 4 words, refilled 5 cycles later
        buf_write(32'h30);
        buf_write(32'h31);
        for (int i = 0; i < 4; i++) expect_beat(32'h30 + 32'(i), (i == 3));
        ren_total = 0;
        hs_total  = 0;
        issue(8'd4);
        seen = 1'b0;
        for (int c = 1; (c <= 40) && !seen; c++) begin
            if (c == 5) begin
                buf_write(32'h32);
                buf_write(32'h33);
            end
            sample();
            if ((c == 3) || (c == 4)) check("t3_ren_empty", 64'(buf_ren), 64'd0);
            if (c == 4) check("t3_valid_gap",  64'(m_valid), 64'd0);
            if (c == 5) check("t3_ren_resume", 64'(buf_ren), 64'd1);
            if (c == 6) check("t3_valid_back", 64'(m_valid), 64'd1);
            if (done) seen = 1'b1;
            advance();
        end
        check("t3_done_seen",  64'(seen),      64'd1);
        check("t3_ren_pulses", 64'(ren_total), 64'd4);
        check("t3_beat_cnt",   64'(beat_cnt),  64'd4);

        // Test 4: illegal lengths rejected; start during RUN ignored
        for (int i = 0; i < 5; i++) buf_write(32'h40 + 32'(i));
        ren_total = 0;
        for (int k = 0; k < 2; k++) begin
            issue(LW'(bad_lens[k]));
            sample();
            check("t4_cmd_err_pulse", 64'(cmd_err), 64'd1);
            check("t4_busy_low",      64'(busy),    64'd0);
            check("t4_no_ren",        64'(buf_ren), 64'd0);
            advance();
            sample();
            check("t4_cmd_err_clear", 64'(cmd_err), 64'd0);
            check("t4_busy_still",    64'(busy),    64'd0);
            advance();
        end
        check("t4_reject_ren", 64'(ren_total), 64'd0);
        expect_beat(32'h40, 1'b0);
        expect_beat(32'h41, 1'b1);
        err_seen = 1'b0;
        hs_total = 0;
        start_len = 8'd2;
        start     = 1'b1;
        sample();
        advance();
        start_len = 8'd3;
        sample();
        check("t4_busy_run", 64'(busy), 64'd1);
        advance();
        start_len = 8'd0;
        sample();
        advance();
        start = 1'b0;
        run_to_done("t4", 20);
        check("t4_ren_pulses", 64'(ren_total), 64'd2);
        check("t4_beat_cnt",   64'(beat_cnt),  64'd2);
        check("t4_no_err",     64'(err_seen),  64'd0);
        check("t4_idle_after", 64'(busy),      64'd0);
        flush_model();

        // Test 5: reset after 3 of 8 beats, then a fresh 2-beat command
        for (int i = 0; i < 8; i++) begin
            buf_write(32'h50 + 32'(i));
            expect_beat(32'h50 + 32'(i), (i == 7));
        end
        hs_total = 0;
        issue(8'd8);
        for (int c = 0; (c < 20) && (hs_total < 3); c++) begin
            sample();
            advance();
        end
        check("t5_three_beats", 64'(hs_total), 64'd3);
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
        flush_model();
        sample();
        check_idle("t5_rst");
        advance();
        buf_write(32'h60);
        buf_write(32'h61);
        expect_beat(32'h60, 1'b0);
        expect_beat(32'h61, 1'b1);
        ren_total = 0;
        hs_total  = 0;
        issue(8'd2);
        run_to_done("t5", 20);
        check("t5_beat_cnt",   64'(beat_cnt),  64'd2);
        check("t5_beats",      64'(hs_total),  64'd2);
        check("t5_ren_pulses", 64'(ren_total), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
